// File: rtl/priority_encoder.sv
// Registered highest-bit-wins priority encoder: index and valid flag of the MSB set in `in`.
// Define PRIORITY_ENCODER_ONEHOT_EN to add the registered one-hot `onehot` output.
module priority_encoder #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  ,
  output logic [WIDTH-1:0] onehot
`endif
);

  logic [OUT_W-1:0] idx;
  logic             any;
  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (en) begin
      out_d   = any ? idx : '0;
      valid_d = any;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] onehot_d, onehot_q;

  always_comb begin
    onehot_d = onehot_q;
    if (en) onehot_d = any ? (WIDTH'(1) << idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) onehot_q <= '0;
    else     onehot_q <= onehot_d;
  end

  assign onehot = onehot_q;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: WIDTH=8 and WIDTH=5 instances checked against an MSB-index model.
module tb_priority_encoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in8;
  logic [2:0] out8;
  logic       valid8;
  logic [4:0] in5;
  logic [2:0] out5;
  logic       valid5;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [7:0] onehot8;
  logic [4:0] onehot5;
`endif

  int errors = 0;
  int checks = 0;

  // Model state: what the registered outputs should currently hold.
  int m_out8, m_val8, m_oh8;
  int m_out5, m_val5, m_oh5;

  priority_encoder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .in(in8), .out(out8), .valid(valid8)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    , .onehot(onehot8)
`endif
  );

  priority_encoder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .in(in5), .out(out5), .valid(valid5)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    , .onehot(onehot5)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // floor(log2(v)) by repeated halving; -1 for zero.
  function automatic int msb_index(input int unsigned v);
    int n = -1;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out8 = 0; m_val8 = 0; m_oh8 = 0;
    m_out5 = 0; m_val5 = 0; m_oh5 = 0;
  endtask

  task automatic model_sample();
    int n8, n5;
    n8 = msb_index(int'(in8));
    n5 = msb_index(int'(in5));
    m_val8 = (n8 >= 0) ? 1 : 0;
    m_out8 = (n8 >= 0) ? n8 : 0;
    m_oh8  = (n8 >= 0) ? (1 << n8) : 0;
    m_val5 = (n5 >= 0) ? 1 : 0;
    m_out5 = (n5 >= 0) ? n5 : 0;
    m_oh5  = (n5 >= 0) ? (1 << n5) : 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_out8"},   32'(out8),   32'(m_out8));
    check({tag, "_valid8"}, 32'(valid8), 32'(m_val8));
    check({tag, "_out5"},   32'(out5),   32'(m_out5));
    check({tag, "_valid5"}, 32'(valid5), 32'(m_val5));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    check({tag, "_onehot8"}, 32'(onehot8), 32'(m_oh8));
    check({tag, "_onehot5"}, 32'(onehot5), 32'(m_oh5));
`endif
  endtask

  // Drive between edges, clock once, then compare just after the edge.
  task automatic apply(input string tag, input logic e, input logic [7:0] v8, input logic [4:0] v5);
    en  = e;
    in8 = v8;
    in5 = v5;
    @(posedge clk);
    if (e) model_sample();
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [7:0] sweep [6];
    int         sweep_exp [6];
    sweep = '{8'b01100011, 8'b00000011, 8'b00011011, 8'b01101011, 8'b11100011, 8'b00010011};
    sweep_exp = '{6, 1, 4, 6, 7, 4};

    // Reset asserted with all requests high: outputs clear with no clock.
    en = 1'b1; in8 = 8'hFF; in5 = 5'h1F; rst = 1'b1;
    model_reset();
    #1;
    compare_all("reset");
    check("reset_abs_out8", 32'(out8), 32'd0);
    check("reset_abs_valid8", 32'(valid8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply("post_reset", 1'b1, 8'hFF, 5'h1F);
    check("post_reset_abs_out8", 32'(out8), 32'd7);

    // Priority sweep against hand-computed indices as well as the model.
    for (int i = 0; i < 6; i++) begin
      apply("sweep", 1'b1, sweep[i], sweep[i][4:0]);
      check("sweep_abs_out8", 32'(out8), 32'(sweep_exp[i]));
      check("sweep_abs_valid8", 32'(valid8), 32'd1);
    end

    // Zero versus bit 0.
    apply("bit0", 1'b1, 8'h01, 5'h01);
    check("bit0_abs_valid8", 32'(valid8), 32'd1);
    apply("zero", 1'b1, 8'h00, 5'h00);
    check("zero_abs_valid8", 32'(valid8), 32'd0);

    // Enable hold.
    apply("hold_load", 1'b1, 8'b00011011, 5'b11011);
    for (int i = 0; i < 3; i++) begin
      apply("hold", 1'b0, 8'b10000000, 5'b10000);
      check("hold_abs_out8", 32'(out8), 32'd4);
    end
    apply("hold_release", 1'b1, 8'b10000000, 5'b10000);
    check("hold_release_abs_out8", 32'(out8), 32'd7);

    // Asynchronous reset pulse between edges.
    apply("mid_load", 1'b1, 8'b01100011, 5'b00011);
    #2 rst = 1'b1;
    model_reset();
    #1;
    compare_all("mid_reset");
    check("mid_reset_abs_out8", 32'(out8), 32'd0);
    #1 rst = 1'b0;
    apply("mid_resume", 1'b1, 8'b01100011, 5'b00011);

    // Exhaustive: all 8-bit vectors; the 5-bit instance sees every 5-bit value repeatedly.
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      b = 8'(v);
      apply("exh", 1'b1, b, b[4:0]);
    end

    // Random vectors with random enable gaps.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] r8;
      logic [4:0] r5;
      logic       e;
      r8 = 8'($urandom_range(0, 255));
      r5 = 5'($urandom_range(0, 31));
      e  = ($urandom_range(0, 3) != 0);
      apply("rand", e, r8, r5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
